multicycle_control_fsm: RTL and testbench

Main control state machine for the multicycle MIPS-subset core. It sequences the shared datapath (one memory, one ALU) through fetch, decode, execute, memory and write-back steps, and emits the per-cycle mux selects and write enables. Its `ALUOp` output drives the ALU function decoder: `00` add, `01` subtract, `10` Funct-decoded.

---
 rtl/mips_ctrl_pkg.sv | 63 ++++++
 rtl/mcfsm_output_decode.sv | 65 ++++++
 rtl/multicycle_control_fsm.sv | 90 +++++++++
 tb/tb_multicycle_control_fsm.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit:
// state encoding, opcode constants, ALUOp / mux-select encodings and the
// raw (unqualified) control word produced by the state decoder.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Moore control word, before qualification by MemReady / Zero / reset.
  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_dst;
    logic       i_or_d;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       pc_write;
    logic       branch;
    logic       mem_req;
  } ctrl_word_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mcfsm_output_decode.sv
// Purely combinational state -> control-word decode for the multicycle
// control FSM.
//   state_i : current FSM state
//   ctrl_o  : raw Moore control word (unqualified enables)
module mcfsm_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state_i,
  output ctrl_word_t ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    ctrl_o.alu_src_b = SRCB_REG;
    ctrl_o.pc_src    = PCSRC_ALURES;
    ctrl_o.alu_op    = ALUOP_ADD;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
      end
      S_DECODE: ctrl_o.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl_o.i_or_d  = 1'b1;
        ctrl_o.mem_req = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_ADDIWB: ctrl_o.reg_write = 1'b1;
      S_BEQ: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.branch    = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_src   = PCSRC_JUMP;
        ctrl_o.pc_write = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle MIPS-subset core.
//   clk, reset            : clock, async active-high reset (to FETCH)
//   Op, Zero, MemReady    : opcode, ALU zero flag, memory-done handshake
//   MemtoReg..PCSrc,ALUOp : datapath mux selects / ALU function class
//   IRWrite..PCEn, MemReq : write enables and memory request
//   IllegalOp             : one-cycle pulse in DECODE for unsupported Op
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUOp,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCEn,
  output logic       MemReq,
  output logic       IllegalOp
);

  state_t     state_q, state_d;
  ctrl_word_t ctrl;
  logic       run;
  logic       pc_write_qual;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEX:   state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  mcfsm_output_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // Reset gates every side effect combinationally so a write in flight is
  // killed in the same cycle reset rises, not at the next edge.
  assign run = ~reset;

  // Only the FETCH PC increment waits for memory; the JUMP write does not.
  assign pc_write_qual = ctrl.pc_write & ((state_q != S_FETCH) | MemReady);

  assign MemtoReg  = ctrl.mem_to_reg;
  assign RegDst    = ctrl.reg_dst;
  assign IorD      = ctrl.i_or_d;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign PCSrc     = ctrl.pc_src;
  assign ALUOp     = ctrl.alu_op;
  assign IRWrite   = run & ctrl.ir_write & MemReady;
  assign MemWrite  = run & ctrl.mem_write & MemReady;
  assign RegWrite  = run & ctrl.reg_write;
  assign PCEn      = run & (pc_write_qual | (ctrl.branch & Zero));
  assign MemReq    = run & ctrl.mem_req;
  assign IllegalOp = run & (state_q == S_DECODE) & ~op_supported(Op);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  typedef enum {T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
                T_EXECUTE, T_ALUWB, T_BEQ, T_ADDIEX, T_ADDIWB, T_JUMP} tb_st_t;

  typedef struct {
    logic [15:0] exp;
    tb_st_t      st;
    int          id;
  } sb_entry_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'b000000;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemtoReg, RegDst, IorD, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc, ALUOp;
  logic       IRWrite, MemWrite, RegWrite, PCEn, MemReq, IllegalOp;

  logic [15:0] obs;
  sb_entry_t   sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          step_id = 0;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .IorD(IorD), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .PCEn(PCEn), .MemReq(MemReq),
    .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  // Order: MemtoReg RegDst IorD ALUSrcA ALUSrcB PCSrc ALUOp
  //        IRWrite MemWrite RegWrite PCEn MemReq IllegalOp
  assign obs = {MemtoReg, RegDst, IorD, ALUSrcA, ALUSrcB, PCSrc, ALUOp,
                IRWrite, MemWrite, RegWrite, PCEn, MemReq, IllegalOp};

  // Expected outputs taken straight from the per-state output table.
  function automatic logic [15:0] model(input tb_st_t st, input logic [5:0] op,
                                        input logic mr, input logic z,
                                        input logic rst);
    logic mtr, rdst, iord, srca, irw, mw, rw, pcen, mreq, ill;
    logic [1:0] srcb, pcs, aop;
    {mtr, rdst, iord, srca, irw, mw, rw, pcen, mreq, ill} = '0;
    srcb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (st)
      T_FETCH:    begin mreq = 1; srcb = 2'b01; irw = mr; pcen = mr; end
      T_DECODE:   begin
        srcb = 2'b11;
        ill = !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                op == 6'b000100 || op == 6'b001000 || op == 6'b000010);
      end
      T_MEMADR, T_ADDIEX: begin srca = 1; srcb = 2'b10; end
      T_MEMREAD:  begin iord = 1; mreq = 1; end
      T_MEMWRITE: begin iord = 1; mreq = 1; mw = mr; end
      T_MEMWB:    begin rw = 1; mtr = 1; end
      T_EXECUTE:  begin srca = 1; aop = 2'b10; end
      T_ALUWB:    begin rw = 1; rdst = 1; end
      T_ADDIWB:   rw = 1;
      T_BEQ:      begin srca = 1; aop = 2'b01; pcs = 2'b01; pcen = z; end
      T_JUMP:     begin pcs = 2'b10; pcen = 1; end
      default:    ;
    endcase
    if (rst) {irw, mw, rw, pcen, mreq, ill} = '0;
    return {mtr, rdst, iord, srca, srcb, pcs, aop, irw, mw, rw, pcen, mreq, ill};
  endfunction

  task automatic push(input tb_st_t st, input logic [5:0] op, input logic mr,
                      input logic z, input logic rst);
    sb_entry_t e;
    e.exp = model(st, op, mr, z, rst);
    e.st  = st;
    e.id  = step_id;
    sb.push_back(e);
    step_id++;
  endtask

  task automatic check();
    sb_entry_t e;
    e = sb.pop_front();
    n_checks++;
    assert (obs === e.exp) n_pass++;
    else $error("FAIL step%0d_%s observed=%b expected=%b", e.id, e.st.name(), obs, e.exp);
    $display("step %0d %s op=%b mr=%b z=%b rst=%b obs=%b exp=%b", e.id, e.st.name(),
             Op, MemReady, Zero, reset, obs, e.exp);
  endtask

  // One clock cycle: drive just after the rising edge, check mid-cycle.
  task automatic cyc(input tb_st_t st, input logic [5:0] op, input logic mr,
                     input logic z, input logic rst);
    Op = op; MemReady = mr; Zero = z; reset = rst;
    push(st, op, mr, z, rst);
    #3;
    check();
    @(posedge clk); #1;
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010,
                         BAD = 6'b111111;

  initial begin
    @(posedge clk); #1;
    // Reset held: enables quiet even with MemReady high.
    cyc(T_FETCH, LW, 1, 0, 1);
    cyc(T_FETCH, LW, 1, 0, 1);
    // lw, no waits: 5 cycles.
    cyc(T_FETCH, LW, 1, 0, 0);
    cyc(T_DECODE, LW, 1, 0, 0);
    cyc(T_MEMADR, LW, 1, 0, 0);
    cyc(T_MEMREAD, LW, 1, 0, 0);
    cyc(T_MEMWB, LW, 1, 0, 0);
    // sw with two wait cycles in MEMWRITE: 6 cycles.
    cyc(T_FETCH, SW, 1, 0, 0);
    cyc(T_DECODE, SW, 1, 0, 0);
    cyc(T_MEMADR, SW, 1, 0, 0);
    cyc(T_MEMWRITE, SW, 0, 0, 0);
    cyc(T_MEMWRITE, SW, 0, 0, 0);
    cyc(T_MEMWRITE, SW, 1, 0, 0);
    // beq taken, then not taken.
    cyc(T_FETCH, BQ, 1, 1, 0);
    cyc(T_DECODE, BQ, 1, 1, 0);
    cyc(T_BEQ, BQ, 1, 1, 0);
    cyc(T_FETCH, BQ, 1, 0, 0);
    cyc(T_DECODE, BQ, 1, 0, 0);
    cyc(T_BEQ, BQ, 1, 0, 0);
    // R-type with one fetch wait.
    cyc(T_FETCH, RT, 0, 0, 0);
    cyc(T_FETCH, RT, 1, 0, 0);
    cyc(T_DECODE, RT, 1, 0, 0);
    cyc(T_EXECUTE, RT, 1, 1, 0);
    cyc(T_ALUWB, RT, 1, 0, 0);
    // addi.
    cyc(T_FETCH, AI, 1, 0, 0);
    cyc(T_DECODE, AI, 1, 0, 0);
    cyc(T_ADDIEX, AI, 1, 0, 0);
    cyc(T_ADDIWB, AI, 1, 0, 0);
    // j.
    cyc(T_FETCH, JJ, 1, 0, 0);
    cyc(T_DECODE, JJ, 1, 0, 0);
    cyc(T_JUMP, JJ, 1, 0, 0);
    // Illegal opcode: pulse in DECODE, then back to FETCH.
    cyc(T_FETCH, BAD, 1, 0, 0);
    cyc(T_DECODE, BAD, 1, 0, 0);
    cyc(T_FETCH, BAD, 0, 0, 0);
    cyc(T_FETCH, BAD, 0, 1, 0);
    // lw with one MEMREAD wait.
    cyc(T_FETCH, LW, 1, 0, 0);
    cyc(T_DECODE, LW, 1, 0, 0);
    cyc(T_MEMADR, LW, 1, 0, 0);
    cyc(T_MEMREAD, LW, 0, 0, 0);
    cyc(T_MEMREAD, LW, 1, 0, 0);
    cyc(T_MEMWB, LW, 1, 0, 0);
    // sw interrupted by reset mid-MEMWRITE.
    cyc(T_FETCH, SW, 1, 0, 0);
    cyc(T_DECODE, SW, 1, 0, 0);
    cyc(T_MEMADR, SW, 1, 0, 0);
    Op = SW; MemReady = 1; Zero = 0; reset = 0;
    push(T_MEMWRITE, SW, 1, 0, 0);
    #1; check();
    #1; reset = 1;
    push(T_FETCH, SW, 1, 0, 1);
    #1; check();
    @(posedge clk); #1;
    // First fetch after reset completes on the first edge with MemReady.
    cyc(T_FETCH, JJ, 1, 0, 0);
    cyc(T_DECODE, JJ, 1, 0, 0);
    cyc(T_JUMP, JJ, 1, 0, 0);
    cyc(T_FETCH, JJ, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
